// File: rtl/video_mux_pkg.sv
// Shared types and helpers for the HDMI source mux: FSM states, vsync
// polarity normalisation and counter sizing.
package video_mux_pkg;

    typedef enum logic [1:0] {
        STARTUP,
        RUN,
        WAIT_VS,
        BLANK
    } state_e;

    // Returns 1 when vsync is at its active level, whatever the polarity.
    function automatic logic vs_active(input logic vs, input logic active_high);
        return active_high ? vs : ~vs;
    endfunction

    // Width of a counter that has to hold values 0..n (never less than 1 bit).
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n == 0) ? 1 : $clog2(n + 1);
    endfunction

endpackage

// File: rtl/power_up_timer.sv
// Saturating power-up delay: done rises after CYCLES clock edges following
// reset release (on the first edge when CYCLES is 0) and stays high until reset.
module power_up_timer
    import video_mux_pkg::*;
#(
    parameter int unsigned CYCLES = 5000000
) (
    input  logic clk,
    input  logic reset,
    output logic done
);

    localparam int unsigned W = cnt_width(CYCLES);
    localparam logic [W-1:0] LAST = (CYCLES == 0) ? '0 : W'(CYCLES - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            done  <= 1'b0;
        end else if (!done) begin
            if (CYCLES == 0 || count == LAST) begin
                done <= 1'b1;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/video_source_mux.sv
// Frame-aligned NUM_CH:1 video source select on HDMI_TX_CLK with power-up hold
// and black-frame insertion after every channel switch.
module video_source_mux
    import video_mux_pkg::*;
#(
    parameter int unsigned NUM_CH         = 4,
    parameter int unsigned DATA_W         = 24,
    parameter int unsigned SEL_W          = $clog2(NUM_CH),
    parameter int unsigned STARTUP_CYCLES = 5000000,
    parameter int unsigned BLANK_FRAMES   = 1,
    parameter bit          VS_ACTIVE_HIGH = 1'b1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [NUM_CH-1:0]        in_de,
    input  logic [NUM_CH-1:0]        in_vsync,
    input  logic [NUM_CH-1:0]        in_hsync,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [SEL_W-1:0]         sel_req,
    output logic                     out_de,
    output logic                     out_vsync,
    output logic                     out_hsync,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         active_sel,
    output logic                     switch_pending,
    output logic                     startup_done
);

    localparam int unsigned BW = cnt_width(BLANK_FRAMES);
    localparam logic [BW-1:0] BLANK_LAST = (BLANK_FRAMES == 0) ? '0 : BW'(BLANK_FRAMES - 1);

    state_e                 state;
    logic [NUM_CH-1:0]      ch_vs;
    logic [(1<<SEL_W)-1:0]  valid_mask;
    logic                   req_valid, vs_edge, cancel, pend_next;
    logic                   vs_prev, data_blank, all_blank;
    logic [SEL_W-1:0]       pend_sel, tgt_sel, route_sel;
    logic [BW-1:0]          blank_cnt;

    power_up_timer #(.CYCLES(STARTUP_CYCLES)) u_power_up_timer (
        .clk   (clk),
        .reset (reset),
        .done  (startup_done)
    );

    always_comb begin
        for (int unsigned k = 0; k < NUM_CH; k++) ch_vs[k] = vs_active(in_vsync[k], VS_ACTIVE_HIGH);
        for (int unsigned k = 0; k < (1 << SEL_W); k++) valid_mask[k] = (k < NUM_CH);
    end

    // Out-of-range selects are masked off here, so they never count as a request.
    always_comb begin
        req_valid  = valid_mask[sel_req];
        vs_edge    = ch_vs[active_sel] && !vs_prev;
        cancel     = req_valid && (sel_req == active_sel);
        pend_next  = req_valid ? (sel_req != active_sel) : switch_pending;
        tgt_sel    = req_valid ? sel_req : pend_sel;
        route_sel  = active_sel;
        data_blank = 1'b0;
        all_blank  = 1'b0;
        case (state)
            STARTUP: all_blank = !startup_done;
            WAIT_VS: begin
                if (!cancel && vs_edge) begin
                    route_sel  = tgt_sel;
                    data_blank = (BLANK_FRAMES != 0);
                end
            end
            BLANK:   data_blank = !(vs_edge && blank_cnt == BLANK_LAST);
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state          <= STARTUP;
            active_sel     <= '0;
            pend_sel       <= '0;
            switch_pending <= 1'b0;
            blank_cnt      <= '0;
            vs_prev        <= 1'b0;
            out_de         <= 1'b0;
            out_vsync      <= 1'b0;
            out_hsync      <= 1'b0;
            out_data       <= '0;
        end else begin
            out_de    <= !all_blank && in_de[route_sel];
            out_hsync <= !all_blank && in_hsync[route_sel];
            out_vsync <= !all_blank && in_vsync[route_sel];
            out_data  <= (all_blank || data_blank) ? '0 : in_data[route_sel * DATA_W +: DATA_W];
            // Edge history follows whichever channel is routed, so a switch never fakes an edge.
            vs_prev   <= ch_vs[route_sel];
            if (req_valid) pend_sel <= sel_req;
            case (state)
                STARTUP: if (startup_done) state <= RUN;
                RUN: begin
                    if (pend_next) begin
                        state          <= WAIT_VS;
                        switch_pending <= 1'b1;
                    end
                end
                WAIT_VS: begin
                    if (cancel) begin
                        state          <= RUN;
                        switch_pending <= 1'b0;
                    end else if (vs_edge) begin
                        active_sel     <= tgt_sel;
                        switch_pending <= 1'b0;
                        blank_cnt      <= '0;
                        state          <= (BLANK_FRAMES == 0) ? RUN : BLANK;
                    end
                end
                BLANK: begin
                    switch_pending <= pend_next;
                    if (vs_edge) begin
                        if (blank_cnt == BLANK_LAST) state <= pend_next ? WAIT_VS : RUN;
                        else blank_cnt <= blank_cnt + 1'b1;
                    end
                end
                default: state <= STARTUP;
            endcase
        end
    end

endmodule

// File: tb/tb_video_source_mux.sv
// Randomised scoreboard bench for video_source_mux (3 channels, 8-cycle
// startup, one black frame per switch) against a frame-level reference model.
module tb_video_source_mux;

    localparam int unsigned NUM_CH       = 3;
    localparam int unsigned DATA_W       = 24;
    localparam int unsigned SEL_W        = 2;
    localparam int unsigned STARTUP      = 8;
    localparam int unsigned BLANK_FRAMES = 1;
    localparam int          H_TOTAL      = 10;
    localparam int          V_TOTAL      = 5;
    localparam int          EXP_W        = 3 + DATA_W + SEL_W + 2;

    // clock / reset block
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                     reset;
    logic [NUM_CH-1:0]        in_de, in_vsync, in_hsync;
    logic [NUM_CH*DATA_W-1:0] in_data;
    logic [SEL_W-1:0]         sel_req;
    logic                     out_de, out_vsync, out_hsync;
    logic [DATA_W-1:0]        out_data;
    logic [SEL_W-1:0]         active_sel;
    logic                     switch_pending, startup_done;

    video_source_mux #(
        .NUM_CH         (NUM_CH),
        .DATA_W         (DATA_W),
        .STARTUP_CYCLES (STARTUP),
        .BLANK_FRAMES   (BLANK_FRAMES),
        .VS_ACTIVE_HIGH (1'b1)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .in_de          (in_de),
        .in_vsync       (in_vsync),
        .in_hsync       (in_hsync),
        .in_data        (in_data),
        .sel_req        (sel_req),
        .out_de         (out_de),
        .out_vsync      (out_vsync),
        .out_hsync      (out_hsync),
        .out_data       (out_data),
        .active_sel     (active_sel),
        .switch_pending (switch_pending),
        .startup_done   (startup_done)
    );

    // scoreboard state
    logic [EXP_W-1:0] exp_q[$];
    int  n_checks  = 0;
    int  n_err     = 0;
    bit  mon_armed = 1'b0;

    // driver state
    logic [SEL_W-1:0]  drv_sel = '0;
    logic              drv_rst = 1'b1;
    bit                fixed_ch0 = 1'b1;
    int                gen_h = H_TOTAL - 1;
    int                gen_v = V_TOTAL - 1;
    logic [DATA_W-1:0] ch_data [NUM_CH];

    // reference model state: frame-level view of what the mux should do
    int   m_edge  = 0;
    int   m_cur   = 0;
    int   m_target = 0;
    int   m_blank = 0;
    logic m_prev  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_push(input logic g_de, input logic g_vs, input logic g_hs);
        logic        rising;
        logic [DATA_W-1:0] e_data;
        if (drv_rst) begin
            m_edge = 0; m_cur = 0; m_target = 0; m_blank = 0; m_prev = 1'b0;
            exp_q.push_back('0);
        end else begin
            m_edge++;
            if (m_edge <= int'(STARTUP)) begin
                exp_q.push_back({3'b000, {DATA_W{1'b0}}, {SEL_W{1'b0}}, 1'b0, 1'(m_edge == int'(STARTUP))});
            end else begin
                if (int'(drv_sel) < int'(NUM_CH)) m_target = int'(drv_sel);
                rising = g_vs && !m_prev;
                if (m_blank > 0) begin
                    if (rising) m_blank--;
                end else if (rising && m_target != m_cur) begin
                    m_cur   = m_target;
                    m_blank = BLANK_FRAMES;
                end
                e_data = (m_blank > 0) ? '0 : ch_data[m_cur];
                exp_q.push_back({g_de, g_vs, g_hs, e_data, SEL_W'(m_cur), 1'(m_target != m_cur), 1'b1});
            end
            m_prev = g_vs;
        end
    endtask

    // One cycle of stimulus: shared timing generator, per-channel random pixels.
    task automatic step();
        logic g_de, g_vs, g_hs;
        @(negedge clk);
        reset   = drv_rst;
        sel_req = drv_sel;
        gen_h++;
        if (gen_h == H_TOTAL) begin
            gen_h = 0;
            gen_v = (gen_v + 1) % V_TOTAL;
        end
        g_vs = (gen_v == 0);
        g_hs = (gen_h < 2);
        g_de = (gen_v != 0) && (gen_h >= 3) && (gen_h < 9);
        for (int k = 0; k < int'(NUM_CH); k++) ch_data[k] = DATA_W'($urandom);
        if (fixed_ch0) ch_data[0] = 24'h123456;
        in_de    = {NUM_CH{g_de}};
        in_vsync = {NUM_CH{g_vs}};
        in_hsync = {NUM_CH{g_hs}};
        for (int k = 0; k < int'(NUM_CH); k++) in_data[k*DATA_W +: DATA_W] = ch_data[k];
        model_push(g_de, g_vs, g_hs);
        mon_armed = 1'b1;
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    // Advance to a timing position; request changes are made from mid-frame spots.
    task automatic run_to(input int v, input int h);
        for (int i = 0; i < H_TOTAL * V_TOTAL && !(gen_v == v && gen_h == h); i++) step();
    endtask

    task automatic set_sel(input int v, input int h, input logic [SEL_W-1:0] s);
        run_to(v, h);
        drv_sel = s;
    endtask

    // monitor: pops one expectation per output cycle
    initial begin
        logic [EXP_W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (mon_armed) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL scoreboard_underflow: got 0 entries expected 1 at %0t", $time);
                end else begin
                    e = exp_q.pop_front();
                    check("out_de",         32'(out_de),         32'(e[30]));
                    check("out_vsync",      32'(out_vsync),      32'(e[29]));
                    check("out_hsync",      32'(out_hsync),      32'(e[28]));
                    check("out_data",       32'(out_data),       32'(e[27:4]));
                    check("active_sel",     32'(active_sel),     32'(e[3:2]));
                    check("switch_pending", 32'(switch_pending), 32'(e[1]));
                    check("startup_done",   32'(startup_done),   32'(e[0]));
                end
            end
        end
    end

    initial begin
        reset    = 1'b1;
        sel_req  = '0;
        in_de    = '0;
        in_vsync = '0;
        in_hsync = '0;
        in_data  = '0;

        // startup with constant ch0 pixel
        drv_rst = 1'b1;
        run(3);
        drv_rst = 1'b0;
        run(20);
        fixed_ch0 = 1'b0;

        // frame-aligned switch to 2
        set_sel(2, 4, 2'd2);
        run(3 * H_TOTAL * V_TOTAL);

        // cancelled request 2 -> 1 -> 2 within one frame
        set_sel(1, 3, 2'd1);
        set_sel(3, 6, 2'd2);
        run(2 * H_TOTAL * V_TOTAL);

        // out-of-range select held for three frames
        set_sel(2, 2, 2'd3);
        run(3 * H_TOTAL * V_TOTAL);

        // switch to 1, then request 2 while the black frame is showing
        set_sel(2, 4, 2'd1);
        run_to(0, 0);
        set_sel(2, 4, 2'd2);
        run(4 * H_TOTAL * V_TOTAL);

        // reset in the middle of a black frame
        set_sel(2, 4, 2'd0);
        run_to(0, 0);
        run_to(2, 4);
        drv_rst = 1'b1;
        step();
        drv_rst = 1'b0;
        run(25);

        // random requests, including out-of-range values, at mid-frame positions
        repeat (30) begin
            set_sel($urandom_range(1, V_TOTAL - 1), $urandom_range(0, H_TOTAL - 2),
                    SEL_W'($urandom_range(0, 3)));
            run($urandom_range(1, 90));
        end
        run(5);

        @(posedge clk);
        #2;
        check("exp_q_drained", 32'(exp_q.size()), 32'd0);
        mon_armed = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
